// File: rtl/vga_scan_gen.sv
// vga_scan_gen: parametrised VGA timing and VRAM read-address generator.
// Sync/blank ride a RD_LAT-deep pipeline so they meet the VRAM data at the output register.
module vga_scan_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RD_LAT   = 1,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [11:0]       vram_data,
    output logic [3:0]        vga_red,
    output logic [3:0]        vga_green,
    output logic [3:0]        vga_blue,
    output logic              vga_h_sync,
    output logic              vga_v_sync,
    output logic              frame_start,
    output logic [10:0]       pix_x,
    output logic [9:0]        pix_y
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int PW = 4 * RD_LAT;
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    logic [DW-1:0] div_q, div_d;
    logic [10:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PW-1:0] pipe_q, pipe_d;
    logic [11:0] rgb_q, rgb_d;
    logic hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic tick, x_wrap, y_wrap, act0, hs0, vs0, first0;
    logic [3:0] dly;
    always_comb begin
        tick   = en && (div_q == DW'(CLK_DIV - 1));
        x_wrap = x_q == 11'(H_TOTAL - 1);
        y_wrap = y_q == 10'(V_TOTAL - 1);
        act0   = (x_q < 11'(H_ACTIVE)) && (y_q < 10'(V_ACTIVE));
        hs0    = (x_q >= 11'(H_ACTIVE + H_FP)) && (x_q < 11'(H_ACTIVE + H_FP + H_SYNC));
        vs0    = (y_q >= 10'(V_ACTIVE + V_FP)) && (y_q < 10'(V_ACTIVE + V_FP + V_SYNC));
        first0 = (x_q == 11'd0) && (y_q == 10'd0);
        // oldest pipeline entry {active, hs, vs, first} sits in the top nibble
        dly    = pipe_q[PW-1 -: 4];
        div_d  = (!en || tick) ? '0 : div_q + DW'(1);
        x_d    = !en ? '0 : !tick ? x_q : x_wrap ? '0 : x_q + 11'd1;
        y_d    = !en ? '0 : !(tick && x_wrap) ? y_q : y_wrap ? '0 : y_q + 10'd1;
        // saturates at the last active pixel, then holds through blanking until (0,0)
        addr_d = !en ? '0 : !tick ? addr_q : (x_wrap && y_wrap) ? '0 :
                 (act0 && addr_q != ADDR_MAX) ? addr_q + ADDR_W'(1) : addr_q;
        pipe_d = !en ? '0 : tick ? PW'({pipe_q, act0, hs0, vs0, first0}) : pipe_q;
        rgb_d  = !en ? '0 : tick ? (dly[3] ? vram_data : '0) : rgb_q;
        hs_d   = !en ? ~HS_POL : tick ? (dly[2] ? HS_POL : ~HS_POL) : hs_q;
        vs_d   = !en ? ~VS_POL : tick ? (dly[1] ? VS_POL : ~VS_POL) : vs_q;
        fs_d   = tick && dly[0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
            pipe_q <= '0;
            rgb_q  <= '0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            fs_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
            pipe_q <= pipe_d;
            rgb_q  <= rgb_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            fs_q   <= fs_d;
        end
    end
    assign vram_addr = addr_q;
    assign {vga_red, vga_green, vga_blue} = rgb_q;
    assign vga_h_sync = hs_q;
    assign vga_v_sync = vs_q;
    assign frame_start = fs_q;
    assign pix_x = x_q;
    assign pix_y = y_q;
endmodule
